// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode 7-segment scan controller with
// double-buffered BCD input, blanking gaps and leading-zero suppression.
// Optional decimal-point support is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_ctrl #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        lz_blank,
`ifdef SEG7_SCAN_DP_EN
  input  logic [3:0]  dp_in,
  output logic        dp_n,
`endif
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

  // Active-low gfedcba patterns; non-decimal nibbles render as a dash.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   pend_q, pend_d, act_q, act_d;
  logic          pend_v_q, pend_v_d, act_v_q, act_v_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          fd_q, fd_d;
  logic          wrap_s, show_s, supp_s;
  logic [3:0]    digit_s;
`ifdef SEG7_SCAN_DP_EN
  logic [3:0]    dp_pend_q, dp_pend_d, dp_act_q, dp_act_d;
  logic          dp_n_q, dp_n_d;
`endif

  // Next-state: scan position, double buffer, and the outputs for the next cycle.
  always_comb begin
    wrap_s = (idx_q == 2'd3) && (cnt_q == CNT_LAST);
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CW'(1);
      idx_d = idx_q;
    end

    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    act_d    = act_q;
    act_v_d  = act_v_q;
`ifdef SEG7_SCAN_DP_EN
    dp_pend_d = dp_pend_q;
    dp_act_d  = dp_act_q;
`endif
    // Transfer happens before the new load so a coincident load waits one frame.
    if (wrap_s && pend_v_q) begin
      act_d    = pend_q;
      act_v_d  = 1'b1;
      pend_v_d = 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp_act_d = dp_pend_q;
`endif
    end else begin
      act_v_d = act_v_q;
    end
    if (load) begin
      pend_d   = value;
      pend_v_d = 1'b1;
`ifdef SEG7_SCAN_DP_EN
      dp_pend_d = dp_in;
`endif
    end else begin
      pend_d = pend_d;
    end

    case (idx_d)
      2'd0:    begin digit_s = act_d[3:0];   supp_s = 1'b0;                   end
      2'd1:    begin digit_s = act_d[7:4];   supp_s = (act_d[15:4]  == 12'd0); end
      2'd2:    begin digit_s = act_d[11:8];  supp_s = (act_d[15:8]  == 8'd0);  end
      2'd3:    begin digit_s = act_d[15:12]; supp_s = (act_d[15:12] == 4'd0);  end
      default: begin digit_s = 4'd0;         supp_s = 1'b0;                   end
    endcase

    show_s = (cnt_d >= BLANK_END);
    if (show_s) begin
      an_d = ~(4'b0001 << idx_d);
    end else begin
      an_d = 4'b1111;
    end
    if (show_s && act_v_d && !(lz_blank && supp_s)) begin
      seg_d = dec7(digit_s);
    end else begin
      seg_d = 7'b1111111;
    end
    fd_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);
`ifdef SEG7_SCAN_DP_EN
    if (show_s) begin
      dp_n_d = ~dp_act_d[idx_d];
    end else begin
      dp_n_d = 1'b1;
    end
`endif
  end

  // State and registered outputs; reset darkens the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      pend_q   <= 16'd0;
      pend_v_q <= 1'b0;
      act_q    <= 16'd0;
      act_v_q  <= 1'b0;
      seg_q    <= 7'b1111111;
      an_q     <= 4'b1111;
      fd_q     <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
      dp_pend_q <= 4'd0;
      dp_act_q  <= 4'd0;
      dp_n_q    <= 1'b1;
`endif
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      act_q    <= act_d;
      act_v_q  <= act_v_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
`ifdef SEG7_SCAN_DP_EN
      dp_pend_q <= dp_pend_d;
      dp_act_q  <= dp_act_d;
      dp_n_q    <= dp_n_d;
`endif
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
`ifdef SEG7_SCAN_DP_EN
  assign dp_n       = dp_n_q;
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (PRESCALE=8, BLANK_CYCLES=2):
// frame-by-frame table of loads and expected digit patterns, checked per cycle.
module tb_seg7_scan_ctrl;

  localparam int PS = 8;
  localparam int BC = 2;
  localparam logic [6:0] DARK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'd0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          la;
    logic [15:0] va;
    int          lb;
    logic [15:0] vb;
    logic        lz;
    logic [3:0][6:0] exp;
  } frame_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  frame_t tbl[9];
  frame_t blank_f;
  exp_t   sb[$];

  seg7_scan_ctrl #(.PRESCALE(PS), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .lz_blank(lz_blank),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk7(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
    end
  endtask

  // Called at a negedge where the scan is at digit 0, counter 0; ends at the next frame start.
  task automatic run_frame(input frame_t f, input int fn);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < PS; c++) begin
        e.an  = (c < BC) ? 4'b1111 : ~(4'b0001 << k);
        e.seg = (c < BC) ? DARK : f.exp[k];
        e.fd  = (k == 3) && (c == PS - 1);
        sb.push_back(e);
      end
    end
    lz_blank = f.lz;
    for (int i = 0; i < 4 * PS; i++) begin
      e = sb.pop_front();
      chk4($sformatf("an_f%0d_c%0d", fn, i), an, e.an);
      chk7($sformatf("seg_f%0d_c%0d", fn, i), seg, e.seg);
      chk1($sformatf("fd_f%0d_c%0d", fn, i), frame_done, e.fd);
      load = 1'b0;
      if (i == f.la) begin
        load = 1'b1;
        value = f.va;
      end else if (i == f.lb) begin
        load = 1'b1;
        value = f.vb;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    blank_f = '{la: -1, va: 16'h0, lb: -1, vb: 16'h0, lz: 1'b0, exp: {DARK, DARK, DARK, DARK}};
    tbl[0] = '{la: 10, va: 16'h1234, lb: -1, vb: 16'h0, lz: 1'b0, exp: {DARK, DARK, DARK, DARK}};
    tbl[1] = '{la: 5, va: 16'h0007, lb: -1, vb: 16'h0, lz: 1'b0,
               exp: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tbl[2] = '{la: -1, va: 16'h0, lb: -1, vb: 16'h0, lz: 1'b1,
               exp: {DARK, DARK, DARK, 7'b1111000}};
    tbl[3] = '{la: 3, va: 16'h1111, lb: 20, vb: 16'h2222, lz: 1'b0,
               exp: {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}};
    tbl[4] = '{la: 31, va: 16'h9C85, lb: -1, vb: 16'h0, lz: 1'b0,
               exp: {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}};
    tbl[5] = '{la: -1, va: 16'h0, lb: -1, vb: 16'h0, lz: 1'b0,
               exp: {7'b0100100, 7'b0100100, 7'b0100100, 7'b0100100}};
    tbl[6] = '{la: 6, va: 16'h0305, lb: 31, vb: 16'h0100, lz: 1'b1,
               exp: {7'b0010000, 7'b0111111, 7'b0000000, 7'b0010010}};
    tbl[7] = '{la: -1, va: 16'h0, lb: -1, vb: 16'h0, lz: 1'b1,
               exp: {DARK, 7'b0110000, 7'b1000000, 7'b0010010}};
    tbl[8] = '{la: -1, va: 16'h0, lb: -1, vb: 16'h0, lz: 1'b1,
               exp: {DARK, 7'b1111001, 7'b1000000, 7'b1000000}};

    repeat (3) @(negedge clk);
    chk4("reset_an", an, 4'b1111);
    chk7("reset_seg", seg, DARK);
    chk1("reset_fd", frame_done, 1'b0);
    rst_n = 1'b1;

    for (int f = 0; f < 9; f++) begin
      run_frame(tbl[f], f);
    end

    // Reset during the digit-2 SHOW phase must darken outputs without a clock edge.
    repeat (2 * PS + 4) @(negedge clk);
    chk4("pre_rst_an", an, 4'b1011);
    chk7("pre_rst_seg", seg, 7'b1111001);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst_an", an, 4'b1111);
    chk7("async_rst_seg", seg, DARK);
    chk1("async_rst_fd", frame_done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(blank_f, 90);
    run_frame(blank_f, 91);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
